// File: rtl/fetch_unit.sv
// Instruction-fetch stage: program counter, synchronous instruction RAM with a
// program-load port, registered instruction output, redirects and a return-address stack.
module fetch_unit #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_PC    = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               load_en,
    input  logic [ADDR_WIDTH-1:0]              load_addr,
    input  logic [DATA_WIDTH-1:0]              load_data,
    input  logic                               stall,
    input  logic                               jump,
    input  logic                               call,
    input  logic                               ret,
    input  logic [ADDR_WIDTH-1:0]              target,
    input  logic [ADDR_WIDTH-1:0]              link_addr,
    output logic [ADDR_WIDTH-1:0]              pc,
    output logic [DATA_WIDTH-1:0]              instr,
    output logic [ADDR_WIDTH-1:0]              instr_pc,
    output logic                               instr_valid,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_count,
    output logic                               stack_err
);

    localparam int CW = $clog2(STACK_DEPTH + 1);
    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] RESET_ADDR = ADDR_WIDTH'(RESET_PC);
    localparam logic [CW-1:0]         FULL_COUNT = CW'(STACK_DEPTH);

    logic [DATA_WIDTH-1:0] mem   [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] stack [2**IW];

    logic          stack_full;
    logic          stack_empty;
    logic          do_push;
    logic [IW-1:0] push_idx;
    logic [IW-1:0] top_idx;

    always_comb begin
        stack_full  = (stack_count == FULL_COUNT);
        stack_empty = (stack_count == '0);
        do_push     = !load_en && !ret && call && !stack_full;
        push_idx    = IW'(stack_count);
        top_idx     = IW'(stack_count - CW'(1));
    end

    // RAM and stack storage carry no reset so they can map onto plain memories.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            stack[push_idx] <= link_addr;
        end
    end

    // Priority: load, ret, call, jump, stall, then a normal fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_ADDR;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            stack_count <= '0;
            stack_err   <= 1'b0;
        end else if (load_en) begin
            pc          <= RESET_ADDR;
            instr_valid <= 1'b0;
        end else if (ret) begin
            instr_valid <= 1'b0;
            if (!stack_empty) begin
                pc          <= stack[top_idx];
                stack_count <= stack_count - CW'(1);
            end else begin
                pc        <= RESET_ADDR;
                stack_err <= 1'b1;
            end
        end else if (call) begin
            instr_valid <= 1'b0;
            pc          <= target;
            if (!stack_full) begin
                stack_count <= stack_count + CW'(1);
            end else begin
                stack_err <= 1'b1;
            end
        end else if (jump) begin
            instr_valid <= 1'b0;
            pc          <= target;
        end else if (!stall) begin
            instr       <= mem[pc];
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            pc          <= pc + ADDR_WIDTH'(1);
        end
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction-fetch stage with program counter, internal instruction RAM, registered instruction output with valid flag, stall, redirect (jump/call/return) and a hardware return-address stack. It sits at the front of the processor pipeline and feeds the decode stage. It also owns a program-load path so the instruction RAM can be written before or between runs.

Parameters:
ADDR_WIDTH, 8, PC and instruction RAM address width; RAM depth is 2^ADDR_WIDTH words.
DATA_WIDTH, 16, instruction word width.
STACK_DEPTH, 4, number of return-address stack entries (>=1).
RESET_PC, 0, PC value after reset and after program load.

Ports:
clk  in  1  single clock; all state updates on rising edge.
rst  in  1  asynchronous, active-high reset.
load_en  in  1  program-load mode; fetch suppressed while high.
load_addr  in  ADDR_WIDTH  RAM write address in load mode.
load_data  in  DATA_WIDTH  RAM write data in load mode.
stall  in  1  hold PC and instruction outputs.
jump  in  1  redirect PC to target.
call  in  1  push link_addr, then redirect PC to target.
ret  in  1  pop stack top into PC.
target  in  ADDR_WIDTH  jump/call destination.
link_addr  in  ADDR_WIDTH  return address pushed on call.
pc  out  ADDR_WIDTH  current fetch address.
instr  out  DATA_WIDTH  fetched instruction (registered).
instr_pc  out  ADDR_WIDTH  address of instr.
instr_valid  out  1  instr holds a valid fetched word.
stack_count  out  clog2(STACK_DEPTH+1)  stack occupancy.
stack_err  out  1  sticky overflow/underflow flag.

Behaviour:
- Reset (async, any time, including mid-load or mid-redirect): pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, stack_count=0, stack_err=0. RAM contents are not cleared.
- Per-edge priority: load_en > ret > call > jump > stall > normal. Only the highest active redirect acts.
- Load: RAM[load_addr] <= load_data. pc <= RESET_PC, instr_valid <= 0. Redirect and stall inputs are ignored. The stack is untouched.
- Normal: instr <= RAM[pc], instr_pc <= pc, instr_valid <= 1, pc <= pc+1 mod 2^ADDR_WIDTH (wraps to 0 from all-ones).
- Fetch latency: 1 cycle from pc to instr. After load_en falls, the first valid instr (RAM[RESET_PC]) appears one edge later.
- Stall (no redirect): pc, instr, instr_pc and instr_valid hold.
- jump: pc <= target, instr_valid <= 0 (in-flight word flushed). Overrides stall.
- call, stack not full: stack[count] <= link_addr, count+1, pc <= target, instr_valid <= 0.
- call, stack full: push dropped, stack_err <= 1, pc <= target, instr_valid <= 0.
- ret, stack not empty: pc <= stack[count-1], count-1, instr_valid <= 0.
- ret, stack empty: stack_err <= 1, pc <= RESET_PC, instr_valid <= 0.
- The first fetch after a redirect proceeds normally on the next non-stalled edge.
- stack_err is cleared only by rst.
- RAM is single-port and synchronous. Read data is undefined for a location written in the same cycle, which cannot occur because fetch is suppressed during load.

Test Plan:
1. Reset, load RAM[0..3]=0x1111,0x2222,0x3333,0x4444, drop load_en -> instr sequence 0x1111..0x4444 with instr_pc 0..3, instr_valid from the first edge after load, pc=4.
2. Preload RAM[255]=0xABCD, jump target=255, run 2 cycles -> instr=0xABCD, instr_pc=255, then pc wraps to 0, then instr_pc=0.
3. Hold stall 3 cycles mid-run at pc=5 -> pc=5 and instr/instr_pc frozen. Assert jump to 0x40 while stalled -> pc=0x40, instr_valid=0 on that edge.
4. Issue 4 calls (link 0x10,0x11,0x12,0x13), then a 5th call -> stack_count=4, stack_err=1. Then 4 rets -> pc 0x13,0x12,0x11,0x10.
5. ret with empty stack -> pc=RESET_PC, stack_err=1. Simultaneous ret+call+jump with stack holding 0x20 -> only ret acts, pc=0x20, count decrements.
6. Assert rst mid-run with count=2 and stack_err=1 -> all outputs at reset values immediately (asynchronously). RAM contents survive and are refetched from RESET_PC.
